// File: rtl/sd_cmd24_write_pkg.sv
// rtl/sd_cmd24_write_pkg.sv - shared constants, codes and state encoding for the CMD24 writer (CRC helper under CMD24_CRC16_EN)
package sd_cmd24_write_pkg;

    localparam logic [7:0] CMD24_BYTE  = 8'h58;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] FILLER      = 8'hFF;

    localparam logic [2:0] DRESP_ACCEPT    = 3'b010;
    localparam logic [2:0] DRESP_CRC_ERR   = 3'b101;
    localparam logic [2:0] DRESP_WRITE_ERR = 3'b110;

    typedef enum logic [2:0] {
        ERR_OK           = 3'd0,
        ERR_R1_TIMEOUT   = 3'd1,
        ERR_R1_NONZERO   = 3'd2,
        ERR_CRC_REJECT   = 3'd3,
        ERR_WRITE_REJECT = 3'd4,
        ERR_BUSY_TIMEOUT = 3'd5,
        ERR_BAD_TOKEN    = 3'd6
    } err_code_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_R1, ST_GAP, ST_TOKEN,
        ST_DATA, ST_CRC, ST_DRESP, ST_BUSY, ST_TAIL
    } state_t;

`ifdef CMD24_CRC16_EN
    // CRC-16-CCITT advanced one bit at a time, MSB first, matching the wire order
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/sd_cmd24_write_spi_byte_xfer.sv
// rtl/sd_cmd24_write_spi_byte_xfer.sv - mode-0 SPI byte engine; done fires in the last high half so the next byte can follow without a gap
module spi_byte_xfer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       ready,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi
);
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          half_end;

    assign half_end = active && (cnt == HALF_LAST);
    assign done     = half_end && sclk && (bit_idx == 3'd7);
    assign ready    = !active || done;
    assign rx_byte  = rx_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b1;
        end else if (ready && start) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            tx_sh   <= {tx_byte[6:0], 1'b0};
            sclk    <= 1'b0;
            mosi    <= tx_byte[7];
        end else if (done) begin
            active <= 1'b0;
            cnt    <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b1;
        end else if (active) begin
            if (half_end) begin
                cnt  <= '0;
                sclk <= ~sclk;
                if (!sclk) begin
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    mosi    <= tx_sh[7];
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sd_cmd24_write.sv
// rtl/sd_cmd24_write.sv - single-block SD CMD24 writer over SPI; CMD24_CRC16_EN enables the data CRC-16
module sd_cmd24_write
    import sd_cmd24_write_pkg::*;
#(
    parameter int HALF_PERIOD  = 2,
    parameter int RESP_TIMEOUT = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic        Clock_100MHz,
    input  logic        Clear,
    input  logic        Start,
    input  logic [31:0] Block_Addr,
    input  logic [7:0]  Wr_Data,
    input  logic        Wr_Valid,
    output logic        Wr_Ready,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [2:0]  Error_Code,
    output logic        CMD24_CS,
    output logic        CMD24_Data_Out,
    output logic        CMD24_CLK,
    input  logic        CMD24_Data_In
);
    localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

    state_t    state, n_state;
    logic [9:0]  cnt, n_cnt;
    logic [15:0] poll, n_poll;
    logic [31:0] addr, n_addr;
    logic        err, n_err;
    err_code_t   code, n_code, fail_code;
    logic        done_r, n_done;
    logic        fail;
    logic [2:0]  cmd_idx;
    logic [7:0]  cmd_tx;
    logic        x_start, x_ready, x_done;
    logic [7:0]  x_tx, x_rx;
`ifdef CMD24_CRC16_EN
    logic [15:0] crc, n_crc;
`endif

    spi_byte_xfer #(.HALF_PERIOD(HALF_PERIOD)) u_xfer (
        .clk     (Clock_100MHz),
        .rst     (Clear),
        .start   (x_start),
        .tx_byte (x_tx),
        .miso    (CMD24_Data_In),
        .ready   (x_ready),
        .done    (x_done),
        .rx_byte (x_rx),
        .sclk    (CMD24_CLK),
        .mosi    (CMD24_Data_Out)
    );

    assign CMD24_CS   = (state == ST_IDLE) || (state == ST_TAIL);
    assign Busy       = (state != ST_IDLE) || done_r;
    assign Done       = done_r;
    assign Error      = err;
    assign Error_Code = code;
    assign Wr_Ready   = (state == ST_DATA) && x_ready;

    always_comb begin
        cmd_idx = x_done ? (cnt[2:0] + 3'd1) : cnt[2:0];
        case (cmd_idx)
            3'd0:    cmd_tx = CMD24_BYTE;
            3'd1:    cmd_tx = addr[31:24];
            3'd2:    cmd_tx = addr[23:16];
            3'd3:    cmd_tx = addr[15:8];
            3'd4:    cmd_tx = addr[7:0];
            default: cmd_tx = FILLER;
        endcase
    end

    always_comb begin
        n_state   = state;
        n_cnt     = cnt;
        n_poll    = poll;
        n_addr    = addr;
        n_err     = err;
        n_code    = code;
        n_done    = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_OK;
        x_start   = 1'b0;
        x_tx      = FILLER;
`ifdef CMD24_CRC16_EN
        n_crc     = crc;
`endif
        case (state)
            ST_IDLE: if (Start && !done_r) begin
                n_state = ST_CMD;
                n_cnt   = '0;
                n_addr  = Block_Addr;
                n_err   = 1'b0;
                n_code  = ERR_OK;
`ifdef CMD24_CRC16_EN
                n_crc   = '0;
`endif
            end
            ST_CMD: if (x_ready) begin
                x_start = 1'b1;
                if (x_done && cnt == 10'd5) begin
                    n_state = ST_R1;
                    n_poll  = '0;
                end else begin
                    x_tx  = cmd_tx;
                    n_cnt = {7'd0, cmd_idx};
                end
            end
            ST_R1: if (x_done) begin
                if (!x_rx[7]) begin
                    if (x_rx == 8'h00) begin
                        n_state = ST_GAP;
                        x_start = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_R1_NONZERO;
                    end
                end else if (poll == RESP_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_R1_TIMEOUT;
                end else begin
                    n_poll  = poll + 16'd1;
                    x_start = 1'b1;
                end
            end
            ST_GAP: if (x_done) begin
                n_state = ST_TOKEN;
                x_start = 1'b1;
                x_tx    = START_TOKEN;
            end
            ST_TOKEN: if (x_done) begin
                n_state = ST_DATA;
                n_cnt   = '0;
            end
            ST_DATA: if (Wr_Valid && x_ready) begin
                x_start = 1'b1;
                x_tx    = Wr_Data;
                n_cnt   = cnt + 10'd1;
`ifdef CMD24_CRC16_EN
                n_crc   = crc16_byte(crc, Wr_Data);
`endif
                if (cnt == 10'd511) begin
                    n_state = ST_CRC;
                    n_cnt   = '0;
                end
            end
            // first done here belongs to the last data byte, then one per CRC byte
            ST_CRC: if (x_done) begin
                x_start = 1'b1;
                if (cnt == 10'd2) begin
                    n_state = ST_DRESP;
                end else begin
                    n_cnt = cnt + 10'd1;
`ifdef CMD24_CRC16_EN
                    x_tx  = (cnt == 10'd0) ? crc[15:8] : crc[7:0];
`endif
                end
            end
            ST_DRESP: if (x_done) begin
                fail      = 1'b1;
                fail_code = ERR_BAD_TOKEN;
                if (!x_rx[4] && x_rx[0]) begin
                    case (x_rx[3:1])
                        DRESP_ACCEPT: begin
                            fail    = 1'b0;
                            n_state = ST_BUSY;
                            n_poll  = '0;
                            x_start = 1'b1;
                        end
                        DRESP_CRC_ERR:   fail_code = ERR_CRC_REJECT;
                        DRESP_WRITE_ERR: fail_code = ERR_WRITE_REJECT;
                        default:         fail_code = ERR_BAD_TOKEN;
                    endcase
                end
            end
            ST_BUSY: if (x_done) begin
                if (x_rx == FILLER) begin
                    n_state = ST_TAIL;
                    x_start = 1'b1;
                end else if (poll == BUSY_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BUSY_TIMEOUT;
                end else begin
                    n_poll  = poll + 16'd1;
                    x_start = 1'b1;
                end
            end
            ST_TAIL: if (x_done) begin
                n_state = ST_IDLE;
                n_done  = 1'b1;
            end
            default: n_state = ST_IDLE;
        endcase
        if (fail) begin
            n_state = ST_TAIL;
            n_err   = 1'b1;
            n_code  = fail_code;
            x_start = 1'b1;
            x_tx    = FILLER;
        end
    end

    always_ff @(posedge Clock_100MHz) begin
        if (Clear) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            poll   <= '0;
            addr   <= '0;
            err    <= 1'b0;
            code   <= ERR_OK;
            done_r <= 1'b0;
        end else begin
            state  <= n_state;
            cnt    <= n_cnt;
            poll   <= n_poll;
            addr   <= n_addr;
            err    <= n_err;
            code   <= n_code;
            done_r <= n_done;
        end
    end

`ifdef CMD24_CRC16_EN
    always_ff @(posedge Clock_100MHz) begin
        if (Clear) crc <= '0;
        else       crc <= n_crc;
    end
`endif
endmodule
